cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Transmit side of the common data bus (CDB) that feeds the reorder buffer's two CDB write channels.
- Collects completed results (value, ROB entry tag) from NUM_FU functional units.
- Buffers each unit's results in a small per-unit FIFO.
- Round-robin arbitration grants up to two results per cycle; granted results are broadcast as registered (value, rob_entry, wrt_en) pairs on channels 1 and 2.

Parameters:
- NUM_FU, 4, number of functional-unit request ports.
- QUEUE_DEPTH, 2, entries per functional-unit FIFO.
- DATA_W, 64, result value width.
- ROB_IDX_W, 5, ROB entry tag width (32-entry ROB).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- flush  input  1  synchronous squash (mispredict); discards all buffered results.
- fu_valid_in  input  NUM_FU  per-unit result valid.
- fu_value_in  input  NUM_FU*DATA_W  packed values; unit i occupies bits [i*DATA_W +: DATA_W].
- fu_rob_entry_in  input  NUM_FU*ROB_IDX_W  packed ROB tags, same packing.
- fu_ready_out  output  NUM_FU  unit i's FIFO can accept this cycle.
- value_out1, value_out2  output  DATA_W  CDB channel values.
- rob_entry_out1, rob_entry_out2  output  ROB_IDX_W  CDB channel ROB tags.
- wrt_en_out1, wrt_en_out2  output  1  CDB channel write enables.
- busy_out  output  1  at least one FIFO non-empty.

Behaviour:
- Reset (async, any time):
  - FIFOs emptied, rr_ptr = 0.
  - All value/rob_entry/wrt_en outputs = 0.
  - fu_ready_out = all 1s; busy_out = 0.
  - Takes effect immediately, mid-operation included; nothing buffered survives.
- Enqueue: on a rising edge where fu_valid_in[i] && fu_ready_out[i], the pair is pushed to FIFO i. If valid is high while ready is low, the input is ignored; the unit must hold it.
- Ready:
  - fu_ready_out[i] = (count_i < QUEUE_DEPTH), combinational from registered count only.
  - No pass-through: a full FIFO refuses input even if dequeued in the same cycle.
- Arbitration (combinational, each cycle):
  - Scan indices rr_ptr, rr_ptr+1, … mod NUM_FU over non-empty FIFOs.
  - First hit goes to channel 1, second hit to channel 2; remaining FIFOs wait.
  - Each FIFO supplies at most one entry per cycle (its head).
- Pointer update:
  - rr_ptr_next = (index of last grant + 1) mod NUM_FU.
  - rr_ptr is unchanged when there are no grants.
  - Wraps from NUM_FU-1 to 0.
- Broadcast:
  - Granted heads are popped and registered into the channel outputs on the same edge.
  - A channel with no grant drives wrt_en = 0, value = 0, rob_entry = 0.
  - If only one grant exists, it is always on channel 1.
- Latency: a result sampled at edge E0 is visible on the CDB after E1 at the earliest (2 cycles from presentation to wrt_en).
- Ordering: per unit FIFO order is preserved; no ordering is guaranteed between units.
- Simultaneous enqueue and dequeue on the same FIFO: count unchanged, and the new entry lands behind the popped head.
- Flush:
  - At the edge where flush = 1: all FIFOs are emptied, both wrt_en outputs go to 0 next cycle, rr_ptr = 0.
  - Enqueues on that edge are discarded; flush has priority over enqueue and grant.
- Identical ROB tags on both channels cannot occur by contract (the ROB issues unique tags); the block does not check for it.
- Throughput: 2 results/cycle maximum.
- Width: rr_ptr is clog2(NUM_FU) bits. Each FIFO count is clog2(QUEUE_DEPTH+1) bits.

Decomposition:
- Shared package/include holds:
  - DATA_W, ROB_IDX_W, ROB_ENTRIES (32).
  - CDB channel count (2).
  - Packed result struct {valid, rob_entry, value}, also used by the ROB and reservation stations.
- One sub-module: cdb_fu_queue.
  - Parameterised QUEUE_DEPTH FIFO with push, pop, flush, full, empty, head outputs, and async reset.
  - Instantiated NUM_FU times.
- Arbiter and output registers stay in cdb_arbiter.

Test Plan:
1. Single result: FU0 presents value 64'hDEAD, rob 3 for one cycle -> two cycles later wrt_en_out1=1, value_out1=DEAD, rob_entry_out1=3, wrt_en_out2=0; next cycle both wrt_en=0, busy_out=0.
2. Full contention: all four FUs valid in the same cycle, rr_ptr=0, tags 0..3 -> broadcast cycle A: ch1=FU0/tag0, ch2=FU1/tag1; cycle A+1: ch1=FU2, ch2=FU3; rr_ptr returns to 0.
3. Pointer wrap: rr_ptr=3, only FU3 (tag 7) and FU0 (tag 9) non-empty -> ch1 tag 7, ch2 tag 9; rr_ptr=1.
4. Backpressure: all FUs push every cycle for 6 cycles -> fu_ready_out drops to 0 on saturated units with count=2; no loss or duplication; every accepted tag appears exactly once, in per-unit order.
5. Flush with all FIFOs full, plus a coincident push on FU2 -> next cycle wrt_en_out1/2=0, fu_ready_out=4'b1111, busy_out=0; no flushed tag ever appears.
6. Reset asserted mid-burst, between clock edges -> outputs zero immediately, without a clock edge; after deassertion, a new FU1 result (tag 12) is broadcast on ch1 with 2-cycle latency.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: widths, channel count and the result record that the
// ROB and reservation stations also consume.
package cdb_arbiter_pkg;

   localparam int CDB_ROB_ENTRIES = 32;
   localparam int CDB_ROB_IDX_W   = $clog2(CDB_ROB_ENTRIES);
   localparam int CDB_DATA_W      = 64;
   localparam int CDB_CHANNELS    = 2;

   typedef struct packed {
      logic                     valid;
      logic [CDB_ROB_IDX_W-1:0] rob_entry;
      logic [CDB_DATA_W-1:0]    value;
   } cdb_result_t;

endpackage

// File: rtl/cdb_fu_queue.sv
// Per-functional-unit result FIFO. A full queue refuses a push even when the head
// is popped on the same edge; flush empties it and outranks push and pop.
module cdb_fu_queue #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 69
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the head is only consumed when the count says valid.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= data_in;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmit side: buffers per-unit results and grants up to two per cycle,
// round-robin from rr_ptr, onto registered broadcast channels 1 and 2.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_FU      = 4,
   parameter int QUEUE_DEPTH = 2,
   parameter int DATA_W      = CDB_DATA_W,
   parameter int ROB_IDX_W   = CDB_ROB_IDX_W
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        flush,
   input  logic [NUM_FU-1:0]           fu_valid_in,
   input  logic [NUM_FU*DATA_W-1:0]    fu_value_in,
   input  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_entry_in,
   output logic [NUM_FU-1:0]           fu_ready_out,
   output logic [DATA_W-1:0]           value_out1,
   output logic [DATA_W-1:0]           value_out2,
   output logic [ROB_IDX_W-1:0]        rob_entry_out1,
   output logic [ROB_IDX_W-1:0]        rob_entry_out2,
   output logic                        wrt_en_out1,
   output logic                        wrt_en_out2,
   output logic                        busy_out
);

   localparam int FU_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam int SUM_W   = FU_W + 1;
   localparam int ENTRY_W = ROB_IDX_W + DATA_W;

   logic [NUM_FU-1:0]       fifo_full;
   logic [NUM_FU-1:0]       fifo_empty;
   logic [NUM_FU-1:0]       fifo_push;
   logic [NUM_FU-1:0]       fifo_pop;
   logic [ENTRY_W-1:0]      fifo_head [NUM_FU];

   logic [FU_W-1:0]         rr_ptr;
   logic [FU_W-1:0]         rr_next;
   logic [FU_W-1:0]         last_idx;
   logic [SUM_W-1:0]        scan_sum;
   logic                    taken;
   logic [CDB_CHANNELS-1:0] grant_vld;
   logic [FU_W-1:0]         grant_idx [CDB_CHANNELS];

   logic [CDB_CHANNELS-1:0] cdb_wrt;
   logic [DATA_W-1:0]       cdb_value [CDB_CHANNELS];
   logic [ROB_IDX_W-1:0]    cdb_rob   [CDB_CHANNELS];

   for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
      assign fifo_push[i] = fu_valid_in[i] && !fifo_full[i];

      cdb_fu_queue #(
         .DEPTH (QUEUE_DEPTH),
         .WIDTH (ENTRY_W)
      ) u_queue (
         .clock   (clock),
         .reset   (reset),
         .flush   (flush),
         .push    (fifo_push[i]),
         .pop     (fifo_pop[i]),
         .data_in ({fu_rob_entry_in[i*ROB_IDX_W +: ROB_IDX_W], fu_value_in[i*DATA_W +: DATA_W]}),
         .full    (fifo_full[i]),
         .empty   (fifo_empty[i]),
         .head    (fifo_head[i])
      );
   end

   assign fu_ready_out = ~fifo_full;
   assign busy_out     = ~&fifo_empty;

   // Walk the units starting at rr_ptr; each non-empty unit takes the next free channel.
   always_comb begin
      grant_vld = '0;
      for (int c = 0; c < CDB_CHANNELS; c++) grant_idx[c] = '0;
      last_idx = '0;
      scan_sum = '0;
      taken    = 1'b0;
      for (int k = 0; k < NUM_FU; k++) begin
         scan_sum = {1'b0, rr_ptr} + SUM_W'(k);
         if (scan_sum >= SUM_W'(NUM_FU)) scan_sum = scan_sum - SUM_W'(NUM_FU);
         if (!fifo_empty[scan_sum[FU_W-1:0]]) begin
            taken = 1'b0;
            for (int c = 0; c < CDB_CHANNELS; c++) begin
               if (!taken && !grant_vld[c]) begin
                  grant_vld[c] = 1'b1;
                  grant_idx[c] = scan_sum[FU_W-1:0];
                  last_idx     = scan_sum[FU_W-1:0];
                  taken        = 1'b1;
               end
            end
         end
      end
   end

   assign rr_next = (last_idx == FU_W'(NUM_FU - 1)) ? '0 : last_idx + FU_W'(1);

   always_comb begin
      fifo_pop = '0;
      for (int c = 0; c < CDB_CHANNELS; c++) begin
         if (grant_vld[c]) fifo_pop[grant_idx[c]] = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rr_ptr <= '0;
         for (int c = 0; c < CDB_CHANNELS; c++) begin
            cdb_wrt[c]   <= 1'b0;
            cdb_value[c] <= '0;
            cdb_rob[c]   <= '0;
         end
      end else if (flush) begin
         rr_ptr <= '0;
         for (int c = 0; c < CDB_CHANNELS; c++) begin
            cdb_wrt[c]   <= 1'b0;
            cdb_value[c] <= '0;
            cdb_rob[c]   <= '0;
         end
      end else begin
         if (|grant_vld) rr_ptr <= rr_next;
         for (int c = 0; c < CDB_CHANNELS; c++) begin
            cdb_wrt[c]   <= grant_vld[c];
            cdb_value[c] <= grant_vld[c] ? fifo_head[grant_idx[c]][DATA_W-1:0] : '0;
            cdb_rob[c]   <= grant_vld[c] ? fifo_head[grant_idx[c]][ENTRY_W-1:DATA_W] : '0;
         end
      end
   end

   assign wrt_en_out1    = cdb_wrt[0];
   assign wrt_en_out2    = cdb_wrt[1];
   assign value_out1     = cdb_value[0];
   assign value_out2     = cdb_value[1];
   assign rob_entry_out1 = cdb_rob[0];
   assign rob_entry_out2 = cdb_rob[1];

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a queue-level reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_cdb_arbiter;

   localparam int NUM_FU = 4;
   localparam int DW     = 64;
   localparam int RW     = 5;
   localparam int QD     = 2;

   typedef struct packed {
      logic [RW-1:0] tag;
      logic [DW-1:0] val;
   } ent_t;

   logic                   clock = 1'b0;
   logic                   reset = 1'b1;
   logic                   flush = 1'b0;
   logic [NUM_FU-1:0]      fu_valid_in = '0;
   logic [NUM_FU*DW-1:0]   fu_value_in = '0;
   logic [NUM_FU*RW-1:0]   fu_rob_entry_in = '0;
   logic [NUM_FU-1:0]      fu_ready_out;
   logic [DW-1:0]          value_out1;
   logic [DW-1:0]          value_out2;
   logic [RW-1:0]          rob_entry_out1;
   logic [RW-1:0]          rob_entry_out2;
   logic                   wrt_en_out1;
   logic                   wrt_en_out2;
   logic                   busy_out;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;
   bit saw_bp  = 1'b0;

   ent_t          mq [NUM_FU][$];
   int            m_rr = 0;
   logic          exp_wrt [2];
   logic [DW-1:0] exp_val [2];
   logic [RW-1:0] exp_rob [2];
   logic [NUM_FU-1:0] cmp_rdy;
   logic              cmp_busy;

   cdb_arbiter dut (
      .clock           (clock),
      .reset           (reset),
      .flush           (flush),
      .fu_valid_in     (fu_valid_in),
      .fu_value_in     (fu_value_in),
      .fu_rob_entry_in (fu_rob_entry_in),
      .fu_ready_out    (fu_ready_out),
      .value_out1      (value_out1),
      .value_out2      (value_out2),
      .rob_entry_out1  (rob_entry_out1),
      .rob_entry_out2  (rob_entry_out2),
      .wrt_en_out1     (wrt_en_out1),
      .wrt_en_out2     (wrt_en_out2),
      .busy_out        (busy_out)
   );

   initial forever #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NUM_FU; i++) mq[i].delete();
      m_rr = 0;
      for (int c = 0; c < 2; c++) begin
         exp_wrt[c] = 1'b0;
         exp_val[c] = '0;
         exp_rob[c] = '0;
      end
   endtask

   // One clock edge: grants come from the state before the edge, then accepted pushes land.
   task automatic model_step();
      bit   rdy [NUM_FU];
      int   ng;
      int   last;
      int   idx;
      ent_t e;
      for (int i = 0; i < NUM_FU; i++) rdy[i] = (mq[i].size() < QD);
      for (int c = 0; c < 2; c++) begin
         exp_wrt[c] = 1'b0;
         exp_val[c] = '0;
         exp_rob[c] = '0;
      end
      ng   = 0;
      last = 0;
      for (int k = 0; k < NUM_FU; k++) begin
         idx = (m_rr + k) % NUM_FU;
         if (ng < 2 && mq[idx].size() > 0) begin
            e = mq[idx].pop_front();
            exp_wrt[ng] = 1'b1;
            exp_val[ng] = e.val;
            exp_rob[ng] = e.tag;
            last = idx;
            ng++;
         end
      end
      if (ng > 0) m_rr = (last + 1) % NUM_FU;
      for (int i = 0; i < NUM_FU; i++) begin
         if (fu_valid_in[i] && rdy[i]) begin
            e.tag = fu_rob_entry_in[i*RW +: RW];
            e.val = fu_value_in[i*DW +: DW];
            mq[i].push_back(e);
         end
      end
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clock or posedge reset);
         if (reset || flush) model_clear();
         else model_step();
      end
   end

   initial forever begin
      @(negedge clock);
      if (chk_en && !reset) begin
         cmp_busy = 1'b0;
         for (int i = 0; i < NUM_FU; i++) begin
            cmp_rdy[i] = (mq[i].size() < QD);
            if (mq[i].size() > 0) cmp_busy = 1'b1;
         end
         check("ch1_wrt_en", wrt_en_out1, exp_wrt[0]);
         check("ch1_value", value_out1, exp_val[0]);
         check("ch1_rob", rob_entry_out1, exp_rob[0]);
         check("ch2_wrt_en", wrt_en_out2, exp_wrt[1]);
         check("ch2_value", value_out2, exp_val[1]);
         check("ch2_rob", rob_entry_out2, exp_rob[1]);
         check("fu_ready", fu_ready_out, cmp_rdy);
         check("busy", busy_out, cmp_busy);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic set_fu(input int i, input logic [DW-1:0] v, input logic [RW-1:0] t);
      fu_valid_in[i]               = 1'b1;
      fu_value_in[i*DW +: DW]      = v;
      fu_rob_entry_in[i*RW +: RW]  = t;
   endtask

   task automatic clear_all();
      fu_valid_in = '0;
   endtask

   // Every unit presents continuously, advancing to a new result only once accepted.
   task automatic stream(input int cycles, input logic [15:0] base);
      logic [NUM_FU-1:0] seen;
      int                seq [NUM_FU];
      for (int i = 0; i < NUM_FU; i++) begin
         seq[i] = 0;
         set_fu(i, 64'(base) + 64'(i * 256), 5'(i * 8));
      end
      for (int c = 0; c < cycles; c++) begin
         seen = fu_ready_out;
         if (seen != 4'hF) saw_bp = 1'b1;
         tick();
         for (int i = 0; i < NUM_FU; i++) begin
            if (seen[i]) begin
               seq[i]++;
               set_fu(i, 64'(base) + 64'(i * 256 + seq[i]), 5'(i * 8 + seq[i] % 8));
            end
         end
      end
   endtask

   initial begin
      repeat (3) tick();
      check("rst_ready", fu_ready_out, 4'hF);
      check("rst_busy", busy_out, 1'b0);
      check("rst_wrt1", wrt_en_out1, 1'b0);
      check("rst_wrt2", wrt_en_out2, 1'b0);
      check("rst_value1", value_out1, '0);
      reset  = 1'b0;
      chk_en = 1'b1;
      tick();

      // single result, two-cycle latency
      set_fu(0, 64'hDEAD, 5'd3);
      tick();
      clear_all();
      tick();
      check("t1_wrt1", wrt_en_out1, 1'b1);
      check("t1_value1", value_out1, 64'hDEAD);
      check("t1_rob1", rob_entry_out1, 5'd3);
      check("t1_wrt2", wrt_en_out2, 1'b0);
      tick();
      check("t1_idle_wrt1", wrt_en_out1, 1'b0);
      check("t1_idle_busy", busy_out, 1'b0);

      // flush re-homes the pointer to unit 0
      flush = 1'b1;
      tick();
      flush = 1'b0;

      // full contention from rr_ptr = 0
      for (int i = 0; i < NUM_FU; i++) set_fu(i, 64'h100 + 64'(i), 5'(i));
      tick();
      clear_all();
      tick();
      check("t2a_rob1", rob_entry_out1, 5'd0);
      check("t2a_rob2", rob_entry_out2, 5'd1);
      check("t2a_wrt2", wrt_en_out2, 1'b1);
      tick();
      check("t2b_rob1", rob_entry_out1, 5'd2);
      check("t2b_rob2", rob_entry_out2, 5'd3);
      check("t2b_value2", value_out2, 64'h103);
      tick();
      check("t2_idle_wrt1", wrt_en_out1, 1'b0);

      // pointer wrap: a lone FU2 grant leaves rr_ptr at 3
      set_fu(2, 64'h2020, 5'd20);
      tick();
      clear_all();
      tick();
      set_fu(3, 64'h77, 5'd7);
      set_fu(0, 64'h99, 5'd9);
      tick();
      clear_all();
      tick();
      check("t3_rob1", rob_entry_out1, 5'd7);
      check("t3_rob2", rob_entry_out2, 5'd9);
      check("t3_value2", value_out2, 64'h99);
      // rr_ptr should now be 1, so FU1 beats FU0
      set_fu(0, 64'hA0, 5'd10);
      set_fu(1, 64'hA1, 5'd11);
      tick();
      clear_all();
      tick();
      check("t3_ptr_rob1", rob_entry_out1, 5'd11);
      check("t3_ptr_rob2", rob_entry_out2, 5'd10);
      tick();

      // backpressure
      saw_bp = 1'b0;
      stream(6, 16'h4000);
      clear_all();
      repeat (8) tick();
      check("t4_backpressure_seen", saw_bp, 1'b1);
      check("t4_drained_busy", busy_out, 1'b0);

      // flush with loaded queues and a coincident push
      stream(4, 16'h5000);
      check("t5_pre_busy", busy_out, 1'b1);
      flush = 1'b1;
      set_fu(2, 64'hF00D, 5'd31);
      tick();
      flush = 1'b0;
      clear_all();
      check("t5_wrt1", wrt_en_out1, 1'b0);
      check("t5_wrt2", wrt_en_out2, 1'b0);
      check("t5_ready", fu_ready_out, 4'hF);
      check("t5_busy", busy_out, 1'b0);
      repeat (3) begin
         tick();
         check("t5_quiet_wrt1", wrt_en_out1, 1'b0);
         check("t5_quiet_wrt2", wrt_en_out2, 1'b0);
      end

      // asynchronous reset between edges
      set_fu(0, 64'hA1, 5'd1);
      set_fu(1, 64'hA2, 5'd2);
      set_fu(2, 64'hA4, 5'd4);
      tick();
      clear_all();
      tick();
      check("t6_pre_wrt1", wrt_en_out1, 1'b1);
      check("t6_pre_rob1", rob_entry_out1, 5'd1);
      check("t6_pre_busy", busy_out, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("t6_async_wrt1", wrt_en_out1, 1'b0);
      check("t6_async_wrt2", wrt_en_out2, 1'b0);
      check("t6_async_value1", value_out1, '0);
      check("t6_async_rob1", rob_entry_out1, '0);
      check("t6_async_ready", fu_ready_out, 4'hF);
      check("t6_async_busy", busy_out, 1'b0);
      #1 reset = 1'b0;
      tick();
      set_fu(1, 64'hC0DE, 5'd12);
      tick();
      clear_all();
      tick();
      check("t6_post_wrt1", wrt_en_out1, 1'b1);
      check("t6_post_rob1", rob_entry_out1, 5'd12);
      check("t6_post_value1", value_out1, 64'hC0DE);
      check("t6_post_wrt2", wrt_en_out2, 1'b0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
